// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the sensor-bus responder and initiator.
// Contents: responder state enum, sensor address ranges, SDA ACK/NACK levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StIgnore
  } i2c_state_e;

  // TMP-style temperature sensors and lux sensors on the shared bus.
  localparam logic [6:0] TempAddrFirst = 7'h48;
  localparam logic [6:0] TempAddrLast  = 7'h4B;
  localparam logic [6:0] LuxAddrFirst  = 7'h44;
  localparam logic [6:0] LuxAddrLast   = 7'h47;

  // Bus level during the ACK slot.
  localparam logic SdaAck  = 1'b0;
  localparam logic SdaNack = 1'b1;

  function automatic logic is_sensor_addr(input logic [6:0] addr);
    return ((addr >= TempAddrFirst) && (addr <= TempAddrLast)) ||
           ((addr >= LuxAddrFirst) && (addr <= LuxAddrLast));
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA line conditioning: 2-flop synchronizers plus a history flop per line,
// producing SCL edge strobes and START/STOP strobes in the clk domain.
// Ports: clk, rst (sync, active high), scl, sda_in (async pads);
//        sda_s (synchronized SDA), scl_rise, scl_fall, start_det, stop_det (1-cycle strobes).
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  // Reset to the idle (released) bus level so no edge is seen on exit from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  always_comb begin
    sda_s     = sda_sync_q;
    scl_rise  = scl_sync_q & ~scl_hist_q;
    scl_fall  = ~scl_sync_q & scl_hist_q;
    // SCL must be high in both samples so an SCL fall racing SDA is not a condition.
    start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  end

endmodule

// File: rtl/i2c_responder.sv
// I2C target answering one 7-bit address: 1/2-byte reads from tx_data (MSB byte first,
// wrapping), 1/2-byte writes captured into rx_data. SCL is sampled, never used as a clock.
// Ports: clk, rst (sync, active high), scl, sda_in, sda_oe (1 = pull SDA low),
//        tx_data/tx_taken (read payload + snapshot pulse),
//        rx_data/rx_valid/rx_two_bytes (completed write), busy (addressed transfer).
module i2c_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] tx_data,
  output logic        tx_taken,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_two_bytes,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;  // ACK slot: 0 before first event, 1 once underway
  logic        nack_q, nack_d;
  logic        rd_idx_q, rd_idx_d;
  logic        wr_active_q, wr_active_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] wr_hold_q, wr_hold_d;
  logic        busy_q, busy_d;
  logic        sda_oe_q, sda_oe_d;
  logic        tx_taken_q, tx_taken_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_two_q, rx_two_d;

  logic [7:0] byte_in;
  logic       byte_done;
  logic       addr_hit;
  logic [7:0] cur_rd_byte;
  logic       next_rd_msb;

  assign byte_in     = {shift_q, sda_s};
  assign byte_done   = scl_rise && (bit_cnt_q == 3'd7);
  assign addr_hit    = (byte_in[7:1] == SLAVE_ADDR);
  assign cur_rd_byte = rd_idx_q ? snap_q[7:0] : snap_q[15:8];
  assign next_rd_msb = rd_idx_q ? snap_q[15] : snap_q[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      nack_q      <= 1'b0;
      rd_idx_q    <= 1'b0;
      wr_active_q <= 1'b0;
      snap_q      <= '0;
      wr_hold_q   <= '0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      tx_taken_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_two_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      nack_q      <= nack_d;
      rd_idx_q    <= rd_idx_d;
      wr_active_q <= wr_active_d;
      snap_q      <= snap_d;
      wr_hold_q   <= wr_hold_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      tx_taken_q  <= tx_taken_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_two_q    <= rx_two_d;
    end
  end

  // Next state. Bus conditions override everything, including a coincident data edge.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = StIdle;
    end else if (start_det) begin
      state_d = StAddr;
    end else begin
      unique case (state_q)
        StAddr:    if (byte_done) state_d = addr_hit ? StAddrAck : StIgnore;
        StAddrAck: if (scl_fall && phase_q) state_d = rw_q ? StRdByte : StWrByte;
        StWrByte:  if (byte_done) state_d = StWrAck;
        StWrAck:   if (scl_fall && phase_q) state_d = StWrByte;
        // Every fall here follows a rise, so a zero count means 8 bits are out.
        StRdByte:  if (scl_fall && (bit_cnt_q == 3'd0)) state_d = StRdAck;
        StRdAck: begin
          if (scl_rise && !phase_q && (sda_s == SdaNack)) state_d = StIgnore;
          else if (scl_fall && phase_q) state_d = StRdByte;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    nack_d      = nack_q;
    rd_idx_d    = rd_idx_q;
    wr_active_d = wr_active_q;
    snap_d      = snap_q;
    wr_hold_d   = wr_hold_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    tx_taken_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_two_d    = rx_two_q;

    if (stop_det || start_det) begin
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      if (wr_active_q && (byte_cnt_q != 2'd0)) begin
        rx_data_d  = wr_hold_q;
        rx_two_d   = (byte_cnt_q == 2'd2);
        rx_valid_d = 1'b1;
      end
      wr_active_d = 1'b0;
      byte_cnt_d  = '0;
      // A repeated START keeps the transfer claimed until its address is judged.
      if (stop_det) busy_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              busy_d  = addr_hit;
              rw_d    = byte_in[0];
              phase_d = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = ~SdaAck;
              if (rw_q) begin
                snap_d     = tx_data;
                tx_taken_d = 1'b1;
              end
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (rw_q) begin
                rd_idx_d = 1'b0;
                sda_oe_d = ~snap_q[15];
              end else begin
                sda_oe_d    = 1'b0;
                wr_active_d = 1'b1;
                byte_cnt_d  = '0;
                wr_hold_d   = '0;
              end
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              nack_d  = (byte_cnt_q == 2'd2);
              if (byte_cnt_q == 2'd0) wr_hold_d[15:8] = byte_in;
              if (byte_cnt_q == 2'd1) wr_hold_d[7:0] = byte_in;
              if (byte_cnt_q != 2'd2) byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = ~(nack_q ? SdaNack : SdaAck);
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
        StRdByte: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
            end else begin
              sda_oe_d = ~cur_rd_byte[3'd7 - bit_cnt_q];
            end
          end
        end
        StRdAck: begin
          if (scl_rise && !phase_q && (sda_s == SdaAck)) phase_d = 1'b1;
          if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            rd_idx_d  = ~rd_idx_q;
            sda_oe_d  = ~next_rd_msb;
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe       = sda_oe_q;
  assign tx_taken     = tx_taken_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_two_bytes = rx_two_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: bit-banged bus master, directed table of transfers,
// randomized transfers against a transaction-level model, and hand-written
// repeated-START / abort / reset sequences.
module tb_i2c_responder;

  localparam logic [6:0] Addr = 7'h48;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_oe;
  logic [15:0] tx_data = 16'h0000;
  logic tx_taken;
  logic [15:0] rx_data;
  logic rx_valid;
  logic rx_two_bytes;
  logic busy;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_responder #(.SLAVE_ADDR(Addr)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl          (scl),
    .sda_in       (sda_bus),
    .sda_oe       (sda_oe),
    .tx_data      (tx_data),
    .tx_taken     (tx_taken),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_two_bytes (rx_two_bytes),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Event monitor.
  int oe_cnt = 0, txt_cnt = 0, rxv_cnt = 0, wide_cnt = 0;
  logic [15:0] rx_cap = '0;
  logic two_cap = 1'b0, rxv_prev = 1'b0, txt_prev = 1'b0;

  always @(posedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (tx_taken) txt_cnt <= txt_cnt + 1;
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_cap  <= rx_data;
      two_cap <= rx_two_bytes;
    end
    if ((rx_valid && rxv_prev) || (tx_taken && txt_prev)) wide_cnt <= wide_cnt + 1;
    rxv_prev <= rx_valid;
    txt_prev <= tx_taken;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected last write payload (low byte is only defined after a 2-byte write).
  logic [7:0] last_hi = 8'h00;
  logic [7:0] last_lo = 8'h00;
  logic lo_known = 1'b1;

  typedef struct packed {
    logic [7:0]  addr_byte;
    logic [1:0]  n;
    logic [23:0] wdata;    // byte i at [23-8*i -: 8]
    logic [15:0] tx;
    logic        exp_aack;
    logic [2:0]  exp_ack;  // ack for write byte i at [2-i]
    logic [23:0] exp_rd;
    logic        exp_txt;
    logic        exp_rxv;
    logic [15:0] exp_rx;
    logic        exp_two;
  } xfer_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    wq(Q);
    sda_m = b;
    wq(Q);
    scl = 1'b1;
    wq(Q);
    s = sda_bus;
    wq(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start;
    if (!scl) begin
      wq(Q);
      sda_m = 1'b1;
      wq(Q);
      scl = 1'b1;
      wq(Q);
    end
    sda_m = 1'b0;
    wq(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop;
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl = 1'b1;
    wq(Q);
    sda_m = 1'b1;
    wq(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic m_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(~m_ack, s);
  endtask

  // Transaction-level reference: what an I2C target at Addr must do.
  function automatic xfer_t model(input logic [6:0] a, input logic rw, input logic [1:0] n,
                                  input logic [23:0] w, input logic [15:0] tx);
    xfer_t x;
    logic hit;
    hit         = (a == Addr);
    x.addr_byte = {a, rw};
    x.n         = n;
    x.wdata     = w;
    x.tx        = tx;
    x.exp_aack  = hit;
    x.exp_ack   = hit ? 3'b110 : 3'b000;
    x.exp_rd    = hit ? {tx[15:8], tx[7:0], tx[15:8]} : 24'hFFFFFF;
    x.exp_txt   = hit & rw;
    x.exp_rxv   = hit & ~rw & (n != 2'd0);
    x.exp_rx    = {w[23:16], (n >= 2'd2) ? w[15:8] : 8'h00};
    x.exp_two   = (n >= 2'd2);
    return x;
  endfunction

  task automatic run_xfer(input xfer_t x);
    int oe0, t0, r0;
    logic aack, a, busy_mid;
    logic [7:0] rb;
    oe0 = oe_cnt;
    t0  = txt_cnt;
    r0  = rxv_cnt;
    tx_data = x.tx;
    i2c_start;
    send_byte(x.addr_byte, aack);
    busy_mid = busy;
    chk("addr_ack", aack, x.exp_aack);
    chk("busy_mid", busy_mid, x.exp_aack);
    if (x.addr_byte[0]) begin
      tx_data = ~x.tx;  // must not affect a transfer already snapshotted
      for (int i = 0; i < int'(x.n); i++) begin
        recv_byte(rb, i != int'(x.n) - 1);
        chk("rd_byte", rb, x.exp_rd[23 - 8 * i -: 8]);
      end
    end else begin
      for (int i = 0; i < int'(x.n); i++) begin
        send_byte(x.wdata[23 - 8 * i -: 8], a);
        chk("wr_ack", a, x.exp_ack[2 - i]);
      end
    end
    i2c_stop;
    chk("busy_end", busy, 1'b0);
    chk("tx_taken_cnt", txt_cnt - t0, x.exp_txt);
    chk("rx_valid_cnt", rxv_cnt - r0, x.exp_rxv);
    if (x.exp_rxv) begin
      chk("rx_hi", rx_cap[15:8], x.exp_rx[15:8]);
      chk("rx_two", two_cap, x.exp_two);
      if (x.exp_two) chk("rx_lo", rx_cap[7:0], x.exp_rx[7:0]);
      last_hi  = x.exp_rx[15:8];
      last_lo  = x.exp_rx[7:0];
      lo_known = x.exp_two;
    end
    chk("rx_hold_hi", rx_data[15:8], last_hi);
    if (lo_known) chk("rx_hold_lo", rx_data[7:0], last_lo);
    if (!x.exp_aack) chk("oe_quiet", oe_cnt - oe0, 0);
  endtask

  xfer_t tbl [7];

  initial begin
    logic a, s;
    logic [7:0] rb;
    logic [3:0] nib;
    int r0, t0;

    tbl[0] = '{addr_byte: 8'h91, n: 2'd2, wdata: 24'h0, tx: 16'h1234, exp_aack: 1'b1,
               exp_ack: 3'b000, exp_rd: 24'h123400, exp_txt: 1'b1, exp_rxv: 1'b0,
               exp_rx: 16'h0, exp_two: 1'b0};
    tbl[1] = '{addr_byte: 8'h93, n: 2'd2, wdata: 24'h0, tx: 16'h5678, exp_aack: 1'b0,
               exp_ack: 3'b000, exp_rd: 24'hFFFF00, exp_txt: 1'b0, exp_rxv: 1'b0,
               exp_rx: 16'h0, exp_two: 1'b0};
    tbl[2] = '{addr_byte: 8'h90, n: 2'd2, wdata: 24'hABCD00, tx: 16'h0, exp_aack: 1'b1,
               exp_ack: 3'b110, exp_rd: 24'h0, exp_txt: 1'b0, exp_rxv: 1'b1,
               exp_rx: 16'hABCD, exp_two: 1'b1};
    tbl[3] = '{addr_byte: 8'h90, n: 2'd3, wdata: 24'h010203, tx: 16'h0, exp_aack: 1'b1,
               exp_ack: 3'b110, exp_rd: 24'h0, exp_txt: 1'b0, exp_rxv: 1'b1,
               exp_rx: 16'h0102, exp_two: 1'b1};
    tbl[4] = '{addr_byte: 8'h92, n: 2'd1, wdata: 24'h770000, tx: 16'h0, exp_aack: 1'b0,
               exp_ack: 3'b000, exp_rd: 24'h0, exp_txt: 1'b0, exp_rxv: 1'b0,
               exp_rx: 16'h0, exp_two: 1'b0};
    tbl[5] = '{addr_byte: 8'h90, n: 2'd0, wdata: 24'h0, tx: 16'h0, exp_aack: 1'b1,
               exp_ack: 3'b000, exp_rd: 24'h0, exp_txt: 1'b0, exp_rxv: 1'b0,
               exp_rx: 16'h0, exp_two: 1'b0};
    tbl[6] = '{addr_byte: 8'h91, n: 2'd3, wdata: 24'h0, tx: 16'hBEEF, exp_aack: 1'b1,
               exp_ack: 3'b000, exp_rd: 24'hBEEFBE, exp_txt: 1'b1, exp_rxv: 1'b0,
               exp_rx: 16'h0, exp_two: 1'b0};

    // Reset state.
    wq(5);
    rst = 1'b0;
    wq(5);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_tx_taken", tx_taken, 1'b0);
    chk("rst_rx_data", rx_data, 16'h0000);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_two", rx_two_bytes, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Directed table.
    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    // Write 1 byte, repeated START, then a 2-byte read.
    r0 = rxv_cnt;
    t0 = txt_cnt;
    tx_data = 16'h1234;
    i2c_start;
    send_byte(8'h90, a);
    chk("sr_addr_ack", a, 1'b1);
    send_byte(8'h5A, a);
    chk("sr_data_ack", a, 1'b1);
    i2c_start;
    chk("sr_rx_valid", rxv_cnt - r0, 1);
    chk("sr_rx_hi", rx_cap[15:8], 8'h5A);
    chk("sr_rx_two", two_cap, 1'b0);
    send_byte(8'h91, a);
    chk("sr_rd_addr_ack", a, 1'b1);
    recv_byte(rb, 1'b1);
    chk("sr_rd0", rb, 8'h12);
    recv_byte(rb, 1'b0);
    chk("sr_rd1", rb, 8'h34);
    i2c_stop;
    chk("sr_tx_taken", txt_cnt - t0, 1);
    chk("sr_rx_valid_total", rxv_cnt - r0, 1);
    chk("sr_busy_end", busy, 1'b0);
    last_hi  = 8'h5A;
    lo_known = 1'b0;

    // STOP after 4 bits of read byte 0 (bit 11 = 1 so the target has released SDA).
    tx_data = 16'h0800;
    i2c_start;
    send_byte(8'h91, a);
    chk("abort_addr_ack", a, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      nib[i] = s;
    end
    chk("abort_bits", nib, 4'h0);
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl = 1'b1;
    wq(Q);
    sda_m = 1'b1;
    wq(5);
    chk("abort_sda_oe", sda_oe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    wq(2 * Q);
    run_xfer(tbl[2]);

    // Reset asserted while the target drives the address ACK.
    r0 = rxv_cnt;
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_xfer(tbl[2].addr_byte[i], s);
    wq(Q);
    chk("ackslot_drive", sda_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_oe", sda_oe, 1'b0);
    chk("rst_release_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1;
    i2c_stop;
    chk("rst_no_rx_valid", rxv_cnt - r0, 0);
    chk("rst_rx_cleared", rx_data, 16'h0000);
    last_hi  = 8'h00;
    last_lo  = 8'h00;
    lo_known = 1'b1;
    run_xfer(tbl[0]);

    // Randomized transfers against the model.
    for (int k = 0; k < 16; k++) begin
      logic [6:0] ra;
      logic rrw;
      logic [1:0] rn;
      ra  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : Addr;
      rrw = 1'($urandom_range(0, 1));
      rn  = rrw ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      run_xfer(model(ra, rrw, rn, 24'($urandom), 16'($urandom)));
    end

    chk("pulse_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
